// File: rtl/rw_mem_sync.sv
// Windowed single-port synchronous RAM with registered read data.
// After reset a CLEAR sweep zeroes one word per cycle; accesses are ignored while busy.
module rw_mem_sync #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int BASE       = 128,
    parameter int DEPTH      = 96
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  WE,
    input  logic                  RE,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  busy,
    output logic                  err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] LO   = (ADDR_WIDTH+1)'(BASE);
    localparam logic [ADDR_WIDTH:0] HI   = (ADDR_WIDTH+1)'(BASE + DEPTH - 1);
    localparam logic [IDX_W-1:0]    LAST = IDX_W'(DEPTH - 1);

    typedef enum logic {CLEAR, IDLE} state_t;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      clr_q, clr_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  valid_q, valid_d;
    logic                  err_q, err_d;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic                  mem_we;
    logic [IDX_W-1:0]      mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    logic [ADDR_WIDTH:0]   addr_ext;
    logic                  en;
    logic [IDX_W-1:0]      idx;

    // Compare one bit wider than the bus so BASE+DEPTH-1 at the top of the map cannot wrap.
    assign addr_ext = {1'b0, address};
    assign en       = (addr_ext >= LO) && (addr_ext <= HI);
    assign idx      = IDX_W'(address - ADDR_WIDTH'(BASE));

    always_comb begin
        state_d   = state_q;
        clr_d     = clr_q;
        dout_d    = dout_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = idx;
        mem_wdata = data_in;
        case (state_q)
            CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_q;
                mem_wdata = '0;
                if (clr_q == LAST) begin
                    state_d = IDLE;
                    clr_d   = '0;
                end else begin
                    clr_d = clr_q + 1'b1;
                end
            end
            IDLE: begin
                if (WE || RE) begin
                    if (!en) begin
                        err_d = 1'b1;
                    end else if (WE) begin
                        mem_we = 1'b1;
                    end else begin
                        dout_d  = mem_q[idx];
                        valid_d = 1'b1;
                    end
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= CLEAR;
            clr_q   <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            clr_q   <= clr_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    // Array has no reset; contents are zeroed only by the CLEAR sweep.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign data_out   = dout_q;
    assign data_valid = valid_q;
    assign err        = err_q;
    assign busy       = (state_q == CLEAR);

endmodule

// File: doc/rw_mem_sync.md
RW_MEM_SYNC -- requirements
Module: rw_mem_sync

Interface
REQ-001 Parameter DATA_WIDTH, default 8: data word width in bits.
REQ-002 Parameter ADDR_WIDTH, default 8: address bus width in bits.
REQ-003 Parameter BASE, default 128: lowest address decoded by this block.
REQ-004 Parameter DEPTH, default 96: number of words; the window is BASE..BASE+DEPTH-1, which SHALL fit in ADDR_WIDTH.
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 address  input  ADDR_WIDTH  system address.
REQ-008 WE  input  1  write enable.
REQ-009 RE  input  1  read enable.
REQ-010 data_in  input  DATA_WIDTH  write data.
REQ-011 data_out  output  DATA_WIDTH  registered read data.
REQ-012 data_valid  output  1  one-cycle pulse: data_out updated by a read this cycle.
REQ-013 busy  output  1  high while the post-reset clear runs; accesses are ignored.
REQ-014 err  output  1  one-cycle pulse: an access request fell outside the window.

Function
REQ-015 EN SHALL be high when BASE <= address <= BASE+DEPTH-1; local index = address-BASE, width ceil(log2(DEPTH)).
REQ-016 FSM states: CLEAR, IDLE; reset entry state is CLEAR.
REQ-017 CLEAR: a clear counter from 0 writes zero to one word per cycle, busy=1, WE/RE ignored, err=0, data_valid=0.
REQ-018 CLEAR -> IDLE on the edge writing index DEPTH-1; busy falls on that edge; clear takes exactly DEPTH cycles.
REQ-019 IDLE with WE=1 and EN=1: data_in is written at the edge; data_out unchanged; data_valid=0.
REQ-020 IDLE with WE=0, RE=1 and EN=1: data_out <= mem[index] at the edge; data_valid=1 for the following cycle (latency 1).
REQ-021 WE=1 and RE=1 together: write has priority; no read occurs and data_valid=0.
REQ-022 Read of the address written in the previous cycle SHALL return the new data.
REQ-023 IDLE with (WE or RE)=1 and EN=0: no memory change, data_out held, err=1 for the following cycle.
REQ-024 IDLE with WE=0 and RE=0: no change; data_out holds its last value.
REQ-025 err and data_valid SHALL never be high in the same cycle.
REQ-026 No address wrap: BASE+DEPTH and BASE-1 are out of window, and the index never aliases.
REQ-027 busy=1 implies err=0 and data_valid=0.

Reset
REQ-028 On reset low, without waiting for clk: state=CLEAR, clear counter=0, data_out=0, data_valid=0, err=0, busy=1.
REQ-029 Reset asserted mid-clear or mid-access SHALL abort the operation and restart the full DEPTH-cycle clear after release.
REQ-030 Memory array contents SHALL not be reset asynchronously; zeroing is done only by the CLEAR sweep.

Verification
REQ-031 Release reset with defaults -> busy=1 for exactly 96 cycles, then 0; a read of 128 and a read of 223 return 0x00 with data_valid pulses.
REQ-032 Write 0xA5 at 130, then read 130 next cycle -> data_out=0xA5 one cycle after the read, data_valid=1 for one cycle.
REQ-033 Read or write at 127, 224 and 0x00 -> err pulses once each; memory and data_out unchanged; data_valid=0.
REQ-034 WE=1, RE=1 at 140 with data_in=0x3C -> no data_valid; a later read of 140 returns 0x3C.
REQ-035 Write 0xFF at 200, pulse reset at clear cycle 40 -> busy stays high 96 cycles after release; a read of 200 returns 0x00.
REQ-036 Write attempt at 150 while busy=1 -> ignored, no err; after clear, a read of 150 returns 0x00.
